i2c_master_burst_tx: RTL

Parametrised I2C master write engine, the successor to the single-byte transmitter. Sends START, 7-bit address + W, then 0..MAX_BYTES data bytes pulled from an upstream byte source, checks ACK after every byte and aborts to STOP on NACK. SCL timing comes from a programmable divider, and SCL clock stretching by the slave is honoured. It sits between the system-side command/FIFO logic and the open-drain pad cells.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_quarter_tick.sv | 30 +++
 rtl/i2c_master_burst_tx.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C burst write master: FSM encodings, quarter
// phases, the R/W bit value and the byte-count width helper.
package i2c_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_WRITE = 1'b0;

  // Bits needed to hold a byte count in 0..max_bytes.
  function automatic int unsigned len_width(input int unsigned max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// SCL quarter-period divider: counts 0..CLK_DIV-1, pulses tick on the last
// count, freezes while the slave stretches SCL and is held at 0 by clear.
module i2c_quarter_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = !clear && !freeze && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master_burst_tx.sv
// I2C master write engine: START, address+W, 0..MAX_BYTES data bytes pulled
// from an upstream source, ACK check per byte, STOP; honours SCL stretching.
module i2c_master_burst_tx
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned LEN_W     = len_width(MAX_BYTES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [6:0]       address,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       data_in,
  output logic             data_req,
  input  logic             sda_in,
  input  logic             scl_in,
  output logic             sda_oe,
  output logic             scl_oe,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [LEN_W-1:0] bytes_sent
);

  logic [2:0]       state, state_nx;
  logic [1:0]       q, q_nx;
  logic [2:0]       bit_cnt, bit_nx;
  logic [7:0]       shreg, sh_nx;
  logic [LEN_W-1:0] remaining, rem_nx;
  logic             is_data, is_data_nx;
  logic             ack_bit, ack_nx;
  logic             nack_nx, busy_nx, done_nx;
  logic [LEN_W-1:0] sent_nx, len_clamped;
  logic             sda_oe_nx, scl_oe_nx;
  logic             tick, freeze, load_byte;

  // Slave is stretching when we released SCL but the line still reads low.
  assign freeze = !scl_oe && !scl_in;

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == ST_IDLE),
    .freeze (freeze),
    .tick   (tick)
  );

  assign len_clamped = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;

  // Next byte is fetched in the final cycle of an ACKed slot with bytes left.
  assign load_byte = tick && (state == ST_ACK) && (q == Q3) && !ack_bit
                     && (remaining != '0);
  assign data_req  = load_byte;

  always_comb begin
    state_nx   = state;
    q_nx       = q;
    bit_nx     = bit_cnt;
    sh_nx      = shreg;
    rem_nx     = remaining;
    is_data_nx = is_data;
    ack_nx     = ack_bit;
    nack_nx    = nack;
    sent_nx    = bytes_sent;
    busy_nx    = busy;
    done_nx    = 1'b0;
    sda_oe_nx  = 1'b0;
    scl_oe_nx  = 1'b0;

    if (state != ST_IDLE && tick) q_nx = q + 2'd1;

    case (state)
      ST_IDLE: begin
        q_nx = Q0;
        if (start) begin
          sh_nx      = {address, I2C_WRITE};
          rem_nx     = len_clamped;
          is_data_nx = 1'b0;
          nack_nx    = 1'b0;
          sent_nx    = '0;
          busy_nx    = 1'b1;
          state_nx   = ST_START;
        end
      end
      ST_START: begin
        if (tick && q == Q3) begin
          bit_nx   = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick && q == Q3) begin
          sh_nx = {shreg[6:0], 1'b0};
          if (bit_cnt == 3'd7) state_nx = ST_ACK;
          else                 bit_nx   = bit_cnt + 3'd1;
        end
      end
      ST_ACK: begin
        if (tick && q == Q2) ack_nx = sda_in;
        if (tick && q == Q3) begin
          if (ack_bit) begin
            nack_nx  = 1'b1;
            state_nx = ST_STOP;
          end else begin
            if (is_data) sent_nx = bytes_sent + LEN_W'(1);
            if (load_byte) begin
              sh_nx      = data_in;
              rem_nx     = remaining - LEN_W'(1);
              is_data_nx = 1'b1;
              bit_nx     = '0;
              state_nx   = ST_SHIFT;
            end else begin
              state_nx = ST_STOP;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick && q == Q3) begin
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // Line drive follows the upcoming state so pads switch on the same edge.
    case (state_nx)
      ST_START: sda_oe_nx = (q_nx >= Q2);
      ST_SHIFT: begin
        scl_oe_nx = (q_nx < Q2);
        sda_oe_nx = !sh_nx[7];
      end
      ST_ACK:   scl_oe_nx = (q_nx < Q2);
      ST_STOP: begin
        scl_oe_nx = (q_nx == Q0);
        sda_oe_nx = (q_nx < Q2);
      end
      default: begin
        sda_oe_nx = 1'b0;
        scl_oe_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      q          <= Q0;
      bit_cnt    <= '0;
      shreg      <= '0;
      remaining  <= '0;
      is_data    <= 1'b0;
      ack_bit    <= 1'b0;
      nack       <= 1'b0;
      bytes_sent <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sda_oe     <= 1'b0;
      scl_oe     <= 1'b0;
    end else begin
      state      <= state_nx;
      q          <= q_nx;
      bit_cnt    <= bit_nx;
      shreg      <= sh_nx;
      remaining  <= rem_nx;
      is_data    <= is_data_nx;
      ack_bit    <= ack_nx;
      nack       <= nack_nx;
      bytes_sent <= sent_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      sda_oe     <= sda_oe_nx;
      scl_oe     <= scl_oe_nx;
    end
  end

endmodule
